// File: rtl/conv_pkg.sv
// Shared types and elaboration-time helpers for the streaming convolution engine.
// No logic of its own; latency and backpressure do not apply.
// Holds the FSM state encoding, the output-dimension rule and a width helper safe for 1-deep ranges.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        OUT,
        DONE
    } conv_state_t;

    // Valid-window count along one axis: no padding, leftover rows/cols dropped.
    function automatic int out_dim(input int p, input int k, input int s);
        return (p - k) / s + 1;
    endfunction

    // Address/counter width that never collapses to zero bits.
    function automatic int clog2_safe(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Signed multiply-accumulate: sext(weight) * zext(pix), summed into acc.
// Latency: product registered one cycle after in_vld, accumulated on the next edge.
// No backpressure; the caller owns sequencing and holds acc stable by dropping in_vld.
module conv_mac_unit #(
    parameter int pix_bits    = 2,
    parameter int weight_bits = 3,
    parameter int acc_bits    = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          in_vld,
    input  logic [pix_bits-1:0]           pix,
    input  logic signed [weight_bits-1:0] weight,
    output logic signed [acc_bits-1:0]    acc
);

    // One extra bit so the zero-extended pixel stays non-negative as a signed operand.
    localparam int PROD_W = pix_bits + weight_bits + 1;

    logic signed [PROD_W-1:0] w_ext;
    logic signed [PROD_W-1:0] p_ext;
    logic signed [PROD_W-1:0] prod_q;
    logic                     prod_vld;

    assign w_ext = PROD_W'(weight);
    assign p_ext = PROD_W'(pix);

    // Product stage: register the signed product and its qualifier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q   <= '0;
            prod_vld <= 1'b0;
        end else begin
            prod_vld <= in_vld;
            if (in_vld) begin
                prod_q <= w_ext * p_ext;
            end
        end
    end

    // Accumulate stage: sign-extend each product to the result width before adding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (prod_vld) begin
            acc <= acc + acc_bits'(prod_q);
        end
    end

endmodule

// File: rtl/conv_stream_engine.sv
// Loads one channel-interleaved frame, then computes every kernel/window sum with one serial MAC.
// Latency: K*K*C+2 cycles per result after the frame is loaded (read, multiply, accumulate).
// Backpressure: need_pic stalls on pic_valid=0; a result is held in OUT until conv_result_ready.
module conv_stream_engine
    import conv_pkg::*;
#(
    parameter int pic_bits         = 2,
    parameter int weight_bits      = 3,
    parameter int kernel_size      = 5,
    parameter int pic_size         = 28,
    parameter int channel          = 3,
    parameter int kernel_number    = 2,
    parameter int stride           = 1,
    parameter int conv_result_bits = $clog2(kernel_size * kernel_size * channel)
                                     + pic_bits + weight_bits + 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                conv_start,
    input  logic [pic_bits-1:0]                 pic,
    input  logic                                pic_valid,
    output logic                                need_pic,
    input  logic                                w_wr_en,
    input  logic [clog2_safe(kernel_number * channel * kernel_size * kernel_size)-1:0] w_wr_addr,
    input  logic [weight_bits-1:0]              w_wr_data,
    output logic                                conv_busy,
    output logic                                conv_finish,
    output logic                                conv_result_valid,
    input  logic                                conv_result_ready,
    output logic signed [conv_result_bits-1:0]  conv_result,
    output logic [clog2_safe(kernel_number)-1:0] conv_result_kernel,
    output logic [clog2_safe(out_dim(pic_size, kernel_size, stride)
                             * out_dim(pic_size, kernel_size, stride))-1:0] conv_result_addr
);

    localparam int KKC      = kernel_size * kernel_size * channel;
    localparam int FRAME_D  = pic_size * pic_size * channel;
    localparam int WMEM_D   = kernel_number * KKC;
    localparam int OUT_SIZE = out_dim(pic_size, kernel_size, stride);
    localparam int FA_W     = clog2_safe(FRAME_D);
    localparam int WA_W     = clog2_safe(WMEM_D);
    localparam int KER_W    = clog2_safe(kernel_number);
    localparam int ADDR_W   = clog2_safe(OUT_SIZE * OUT_SIZE);
    localparam int K_W      = clog2_safe(kernel_size);
    localparam int C_W      = clog2_safe(channel);
    localparam int O_W      = clog2_safe(OUT_SIZE);
    localparam int MC_W     = clog2_safe(KKC + 2);

    conv_state_t state_q, state_d;

    logic [pic_bits-1:0]    frame_mem [FRAME_D];
    logic [weight_bits-1:0] w_mem     [WMEM_D];

    logic [FA_W-1:0]        ld_cnt;
    logic [MC_W-1:0]        mcnt;
    logic [C_W-1:0]         mc;
    logic [K_W-1:0]         mkx, mky;
    logic [KER_W-1:0]       n_q;
    logic [O_W-1:0]         ox_q, oy_q;

    logic [FA_W-1:0]        frame_raddr;
    logic [WA_W-1:0]        w_raddr;
    logic [pic_bits-1:0]    pix_rd;
    logic [weight_bits-1:0] w_rd;
    logic                   rd_vld;

    logic ld_last, mac_last, issue, last_n, last_ox, last_oy, acc_clr;

    assign ld_last  = (ld_cnt == FA_W'(FRAME_D - 1));
    // MAC spans KKC issue cycles plus two drain cycles for the read and product stages.
    assign mac_last = (mcnt == MC_W'(KKC + 1));
    assign issue    = (state_q == MAC) && (mcnt < MC_W'(KKC));
    assign acc_clr  = (state_q == MAC) && (mcnt == '0);
    assign last_n   = (n_q == KER_W'(kernel_number - 1));
    assign last_ox  = (ox_q == O_W'(OUT_SIZE - 1));
    assign last_oy  = (oy_q == O_W'(OUT_SIZE - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs; everything idles low.
    always_comb begin
        state_d           = state_q;
        need_pic          = 1'b0;
        conv_busy         = 1'b0;
        conv_finish       = 1'b0;
        conv_result_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (conv_start) state_d = LOAD;
            end
            LOAD: begin
                need_pic  = 1'b1;
                conv_busy = 1'b1;
                if (pic_valid && ld_last) state_d = MAC;
            end
            MAC: begin
                conv_busy = 1'b1;
                if (mac_last) state_d = OUT;
            end
            OUT: begin
                conv_busy         = 1'b1;
                conv_result_valid = 1'b1;
                if (conv_result_ready) begin
                    state_d = (last_n && last_ox && last_oy) ? DONE : MAC;
                end
            end
            DONE: begin
                conv_finish = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Load, tap and output-position counters; all wrap to zero at the end of their range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt <= '0;
            mcnt   <= '0;
            mc     <= '0;
            mkx    <= '0;
            mky    <= '0;
            n_q    <= '0;
            ox_q   <= '0;
            oy_q   <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (pic_valid) ld_cnt <= ld_last ? '0 : ld_cnt + FA_W'(1);
                end
                MAC: begin
                    mcnt <= mac_last ? '0 : mcnt + MC_W'(1);
                    if (issue) begin
                        if (mc == C_W'(channel - 1)) begin
                            mc <= '0;
                            if (mkx == K_W'(kernel_size - 1)) begin
                                mkx <= '0;
                                mky <= (mky == K_W'(kernel_size - 1)) ? '0 : mky + K_W'(1);
                            end else begin
                                mkx <= mkx + K_W'(1);
                            end
                        end else begin
                            mc <= mc + C_W'(1);
                        end
                    end
                end
                OUT: begin
                    if (conv_result_ready) begin
                        if (last_n) begin
                            n_q <= '0;
                            if (last_ox) begin
                                ox_q <= '0;
                                oy_q <= last_oy ? '0 : oy_q + O_W'(1);
                            end else begin
                                ox_q <= ox_q + O_W'(1);
                            end
                        end else begin
                            n_q <= n_q + KER_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tap addresses: window origin (oy*stride, ox*stride), channel innermost.
    always_comb begin
        frame_raddr = FA_W'(((int'(oy_q) * stride + int'(mky)) * pic_size
                             + int'(ox_q) * stride + int'(mkx)) * channel + int'(mc));
        w_raddr     = WA_W'(((int'(n_q) * channel + int'(mc)) * kernel_size
                             + int'(mky)) * kernel_size + int'(mkx));
        conv_result_addr = ADDR_W'(int'(oy_q) * OUT_SIZE + int'(ox_q));
    end

    assign conv_result_kernel = n_q;

    // Memories: frame written during LOAD, weights only while idle; contents survive reset.
    always_ff @(posedge clk) begin
        if (state_q == LOAD && pic_valid) frame_mem[ld_cnt] <= pic;
        if (state_q == IDLE && w_wr_en)   w_mem[w_wr_addr]  <= w_wr_data;
        pix_rd <= frame_mem[frame_raddr];
        w_rd   <= w_mem[w_raddr];
    end

    // Read-data qualifier follows the issue strobe by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= issue;
        end
    end

    conv_mac_unit #(
        .pix_bits   (pic_bits),
        .weight_bits(weight_bits),
        .acc_bits   (conv_result_bits)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr   (acc_clr),
        .in_vld(rd_vld),
        .pix   (pix_rd),
        .weight($signed(w_rd)),
        .acc   (conv_result)
    );

endmodule

// File: tb/tb_conv_stream_engine.sv
// Bench for conv_stream_engine: P=6, K=3, C=1, N=2; one stride-1 and one stride-2 instance.
// Expected results come from a direct convolution over bench-held image/weight arrays.
// A monitor per instance pops its queue on every valid&ready and compares result/kernel/addr.
module tb_conv_stream_engine;

    localparam int P = 6;
    localparam int K = 3;
    localparam int N = 2;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b, pic_valid, w_wr_en, rdy;
    logic [1:0] pic;
    logic [4:0] w_wr_addr;
    logic [2:0] w_wr_data;

    logic need_a, busy_a, fin_a, vld_a;
    logic signed [9:0] res_a;
    logic [0:0] ker_a;
    logic [3:0] addr_a;

    logic need_b, busy_b, fin_b, vld_b;
    logic signed [9:0] res_b;
    logic [0:0] ker_b;
    logic [1:0] addr_b;

    typedef struct {
        int res;
        int ker;
        int addr;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int img[P*P];
    int wts[N*K*K];

    int chk_cnt = 0;
    int err_cnt = 0;
    int hs_a = 0, hs_b = 0;
    int fin_cnt_a = 0, fin_cnt_b = 0;

    always #5 clk = ~clk;

    conv_stream_engine #(
        .pic_bits(2), .weight_bits(3), .kernel_size(K), .pic_size(P),
        .channel(1), .kernel_number(N), .stride(1)
    ) dut_a (
        .clk(clk), .rst(rst), .conv_start(start_a), .pic(pic), .pic_valid(pic_valid),
        .need_pic(need_a), .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
        .conv_busy(busy_a), .conv_finish(fin_a), .conv_result_valid(vld_a),
        .conv_result_ready(rdy), .conv_result(res_a), .conv_result_kernel(ker_a),
        .conv_result_addr(addr_a)
    );

    conv_stream_engine #(
        .pic_bits(2), .weight_bits(3), .kernel_size(K), .pic_size(P),
        .channel(1), .kernel_number(N), .stride(2)
    ) dut_b (
        .clk(clk), .rst(rst), .conv_start(start_b), .pic(pic), .pic_valid(pic_valid),
        .need_pic(need_b), .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
        .conv_busy(busy_b), .conv_finish(fin_b), .conv_result_valid(vld_b),
        .conv_result_ready(rdy), .conv_result(res_b), .conv_result_kernel(ker_b),
        .conv_result_addr(addr_b)
    );

    task automatic check(input string name, input int act, input int req);
        chk_cnt++;
        if (act != req) begin
            err_cnt++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    // Monitors: sample mid-cycle, so a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && vld_a && rdy) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_result", 0, 1);
            end else begin
                e = q_a.pop_front();
                check("a_result", int'(res_a), e.res);
                check("a_kernel", int'(ker_a), e.ker);
                check("a_addr", int'(addr_a), e.addr);
            end
            hs_a++;
        end
        if (!rst && fin_a) fin_cnt_a++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && vld_b && rdy) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_result", 0, 1);
            end else begin
                e = q_b.pop_front();
                check("b_result", int'(res_b), e.res);
                check("b_kernel", int'(ker_b), e.ker);
                check("b_addr", int'(addr_b), e.addr);
            end
            hs_b++;
        end
        if (!rst && fin_b) fin_cnt_b++;
    end

    // Reference convolution over img/wts; results queued in raster order, kernels inner.
    task automatic push_expected(input int sel);
        int s, od, sum;
        exp_t e;
        s  = (sel == 0) ? 1 : 2;
        od = (P - K) / s + 1;
        for (int oy = 0; oy < od; oy++)
            for (int ox = 0; ox < od; ox++)
                for (int n = 0; n < N; n++) begin
                    sum = 0;
                    for (int ky = 0; ky < K; ky++)
                        for (int kx = 0; kx < K; kx++)
                            sum += img[(oy*s + ky)*P + ox*s + kx] * wts[n*K*K + ky*K + kx];
                    e.res  = sum;
                    e.ker  = n;
                    e.addr = oy*od + ox;
                    if (sel == 0) q_a.push_back(e);
                    else          q_b.push_back(e);
                end
    endtask

    task automatic set_weights(input int w0, input int w1);
        for (int i = 0; i < N*K*K; i++) begin
            wts[i]    = (i < K*K) ? w0 : w1;
            w_wr_en   = 1'b1;
            w_wr_addr = 5'(i);
            w_wr_data = 3'(wts[i]);
            @(posedge clk); #1;
        end
        w_wr_en = 1'b0;
    endtask

    // Fill img (constant or ramp pixel=x, clipped to 2 bits), queue expectations, start, stream.
    task automatic load_frame(input int sel, input int ramp, input int val, input int gap);
        int guard;
        for (int i = 0; i < P*P; i++) img[i] = ramp ? ((i % P) & 3) : val;
        push_expected(sel);
        if (sel == 0) start_a = 1'b1;
        else          start_b = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < P*P; i++) begin
            pic       = 2'(img[i]);
            pic_valid = 1'b1;
            @(negedge clk);
            guard = 0;
            while (!((sel == 0) ? need_a : need_b) && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) check("need_pic_timeout", 0, 1);
            @(posedge clk); #1;
            pic_valid = 1'b0;
            if (gap != 0 && i < P*P - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_run(input int sel, input int fin_tgt, input int hs_tgt);
        for (int i = 0; i < 4000; i++) begin
            if (((sel == 0) ? fin_cnt_a : fin_cnt_b) >= fin_tgt) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        if (sel == 0) begin
            check("a_finish_pulses", fin_cnt_a, fin_tgt);
            check("a_result_count", hs_a, hs_tgt);
            check("a_queue_left", q_a.size(), 0);
            check("a_busy_after", int'(busy_a), 0);
        end else begin
            check("b_finish_pulses", fin_cnt_b, fin_tgt);
            check("b_result_count", hs_b, hs_tgt);
            check("b_queue_left", q_b.size(), 0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int guard;
        int fin_before;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; pic_valid = 1'b0; pic = '0;
        w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0; rdy = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_need_pic", int'(need_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_valid", int'(vld_a), 0);
        check("rst_finish", int'(fin_a), 0);
        check("rst_result", int'(res_a), 0);
        check("rst_kernel", int'(ker_a), 0);
        check("rst_addr", int'(addr_a), 0);
        @(posedge clk); #1;

        // All ones: every result 9, kernels alternate, addr 0..15.
        set_weights(1, 1);
        hs_a = 0;
        load_frame(0, 0, 1, 0);
        wait_run(0, 1, 32);

        // Stride 2 on a ramp: k0 sums 9 / 15 per row pair, k1 the negation; addr 0..3.
        set_weights(1, -1);
        hs_b = 0;
        load_frame(1, 1, 0, 0);
        wait_run(1, 1, 8);

        // Pixels 3, weights -1 / +3 (-27 / 81); stall ready for 5 cycles on result 3.
        set_weights(-1, 3);
        hs_a = 0;
        load_frame(0, 0, 3, 0);
        guard = 0;
        while (hs_a < 3 && guard < 2000) begin @(posedge clk); #1; guard++; end
        rdy = 1'b0;
        @(negedge clk);
        guard = 0;
        while (!vld_a && guard < 100) begin @(negedge clk); guard++; end
        check("stall_valid_seen", int'(vld_a), 1);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", int'(vld_a), 1);
            if (q_a.size() > 0) begin
                check("stall_result", int'(res_a), q_a[0].res);
                check("stall_kernel", int'(ker_a), q_a[0].ker);
                check("stall_addr", int'(addr_a), q_a[0].addr);
            end
            @(posedge clk); #1;
            if (i < 4) @(negedge clk);
        end
        rdy = 1'b1;
        wait_run(0, 2, 32);

        // Gapped load, then start / weight writes / pic_valid while computing: all ignored.
        set_weights(1, 1);
        hs_a = 0;
        load_frame(0, 0, 1, 1);
        for (int i = 0; i < N*K*K; i++) begin
            start_a = 1'b1; w_wr_en = 1'b1; w_wr_addr = 5'(i); w_wr_data = 3'd3;
            pic_valid = 1'b1;
            @(negedge clk);
            if (i == 4) check("need_pic_in_mac", int'(need_a), 0);
            if (i == 5) check("busy_in_mac", int'(busy_a), 1);
            @(posedge clk); #1;
        end
        start_a = 1'b0; w_wr_en = 1'b0; pic_valid = 1'b0;
        wait_run(0, 3, 32);

        // Reset during MAC after 10 results, then a full rerun on the retained weights.
        hs_a = 0;
        load_frame(0, 0, 1, 0);
        guard = 0;
        while (hs_a < 10 && guard < 2000) begin @(posedge clk); #1; guard++; end
        check("pre_reset_results", hs_a, 10);
        fin_before = fin_cnt_a;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", int'(busy_a), 0);
        check("midrst_valid", int'(vld_a), 0);
        check("midrst_need_pic", int'(need_a), 0);
        check("midrst_finish", int'(fin_a), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        q_a.delete();
        hs_a = 0;
        repeat (3) @(posedge clk); #1;
        check("midrst_no_finish", fin_cnt_a, fin_before);
        load_frame(0, 0, 1, 0);
        wait_run(0, fin_before + 1, 32);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
